// File: rtl/alu_result_stage.sv
// alu_result_stage: EX->WB stage downstream of the ALU.
//   Buffers ALU results in a 2-entry skid buffer (main M, skid S) with a
//   valid/ready handshake toward writeback. It also owns the architectural
//   flags register fed back to the ALU, resolves BRFL into a branch-taken bit,
//   and keeps a saturating count of overflowing arithmetic ops.
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   flush              drop all buffered entries
//   in_valid/in_ready  upstream handshake (in_ready registered)
//   in_result/in_flags/in_func/in_rd/in_wb_en   ALU op payload
//   out_valid/out_ready                         writeback handshake
//   out_result/out_rd/out_wb_en/out_branch_taken   head entry (always M)
//   flags_q            architectural flags, to ALU flags_in
//   ovf_count          saturating overflow-event count
module alu_result_stage #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned REG_W     = 5,
  parameter int unsigned FLAGS_W   = 3,
  parameter int unsigned OVF_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_W-1:0]    in_result,
  input  logic [FLAGS_W-1:0]   in_flags,
  input  logic [5:0]           in_func,
  input  logic [REG_W-1:0]     in_rd,
  input  logic                 in_wb_en,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_W-1:0]    out_result,
  output logic [REG_W-1:0]     out_rd,
  output logic                 out_wb_en,
  output logic                 out_branch_taken,
  output logic [FLAGS_W-1:0]   flags_q,
  output logic [OVF_CNT_W-1:0] ovf_count
);

  localparam logic [5:0] FUNC_ADD  = 6'b100000;
  localparam logic [5:0] FUNC_SUB  = 6'b100010;
  localparam logic [5:0] FUNC_MUL  = 6'b011000;
  localparam logic [5:0] FUNC_DIV  = 6'b011010;
  localparam logic [5:0] FUNC_BRFL = 6'b111111;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_TWO   = 2'b10
  } state_t;

  state_t                 r_state;
  logic                   r_in_ready;
  logic                   r_out_valid;

  // Main entry (head, drives the outputs)
  logic [DATA_W-1:0]      r_m_result;
  logic [REG_W-1:0]       r_m_rd;
  logic                   r_m_wb_en;
  logic                   r_m_br;

  // Skid entry
  logic [DATA_W-1:0]      r_s_result;
  logic [REG_W-1:0]       r_s_rd;
  logic                   r_s_wb_en;
  logic                   r_s_br;

  logic [FLAGS_W-1:0]     r_flags;
  logic [OVF_CNT_W-1:0]   r_ovf_cnt;

  logic                   w_accept;
  logic                   w_deliver;
  logic                   w_is_brfl;
  logic                   w_is_arith;
  logic                   w_cap_wb_en;
  logic                   w_cap_br;
  logic                   w_ovf_sat;

  // Handshake and capture decode
  always_comb begin
    w_accept    = in_valid & r_in_ready;
    w_deliver   = r_out_valid & out_ready;
    w_is_brfl   = (in_func == FUNC_BRFL);
    w_is_arith  = (in_func == FUNC_ADD) || (in_func == FUNC_SUB) ||
                  (in_func == FUNC_MUL) || (in_func == FUNC_DIV);
    // BRFL never writes the register file; its outcome rides in result[0]
    w_cap_wb_en = w_is_brfl ? 1'b0 : in_wb_en;
    w_cap_br    = w_is_brfl & in_result[0];
    w_ovf_sat   = &r_ovf_cnt;
  end

  // Skid-buffer FSM, flags register and overflow counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_EMPTY;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_m_result  <= '0;
      r_m_rd      <= '0;
      r_m_wb_en   <= 1'b0;
      r_m_br      <= 1'b0;
      r_s_result  <= '0;
      r_s_rd      <= '0;
      r_s_wb_en   <= 1'b0;
      r_s_br      <= 1'b0;
      r_flags     <= '0;
      r_ovf_cnt   <= '0;
    end else if (flush) begin
      // Kill: a same-cycle accept is dropped along with its side effects;
      // a same-cycle deliver needs no action since everything is cleared.
      r_state     <= ST_EMPTY;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      if (w_accept && w_is_arith) begin
        r_flags <= in_flags;
        if (in_flags[0] && !w_ovf_sat) begin
          r_ovf_cnt <= r_ovf_cnt + OVF_CNT_W'(1);
        end
      end

      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            r_m_result  <= in_result;
            r_m_rd      <= in_rd;
            r_m_wb_en   <= w_cap_wb_en;
            r_m_br      <= w_cap_br;
            r_out_valid <= 1'b1;
            r_state     <= ST_ONE;
          end
        end

        ST_ONE: begin
          if (w_accept && w_deliver) begin
            r_m_result <= in_result;
            r_m_rd     <= in_rd;
            r_m_wb_en  <= w_cap_wb_en;
            r_m_br     <= w_cap_br;
          end else if (w_accept) begin
            // Head stalled: park the new entry and stop accepting
            r_s_result <= in_result;
            r_s_rd     <= in_rd;
            r_s_wb_en  <= w_cap_wb_en;
            r_s_br     <= w_cap_br;
            r_in_ready <= 1'b0;
            r_state    <= ST_TWO;
          end else if (w_deliver) begin
            r_out_valid <= 1'b0;
            r_state     <= ST_EMPTY;
          end
        end

        ST_TWO: begin
          if (w_deliver) begin
            r_m_result <= r_s_result;
            r_m_rd     <= r_s_rd;
            r_m_wb_en  <= r_s_wb_en;
            r_m_br     <= r_s_br;
            r_in_ready <= 1'b1;
            r_state    <= ST_ONE;
          end
        end

        default: begin
          r_state     <= ST_EMPTY;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready         = r_in_ready;
  assign out_valid        = r_out_valid;
  assign out_result       = r_m_result;
  assign out_rd           = r_m_rd;
  assign out_wb_en        = r_m_wb_en;
  assign out_branch_taken = r_m_br;
  assign flags_q          = r_flags;
  assign ovf_count        = r_ovf_cnt;

endmodule

// File: tb/tb_alu_result_stage.sv
// tb_alu_result_stage: directed stimulus with a queue scoreboard; a negedge
// monitor pops an expected entry each time writeback takes the head.
module tb_alu_result_stage;

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned REG_W     = 5;
  localparam int unsigned FLAGS_W   = 3;
  localparam int unsigned OVF_CNT_W = 2;

  localparam logic [5:0] F_ADD  = 6'b100000;
  localparam logic [5:0] F_SUB  = 6'b100010;
  localparam logic [5:0] F_MUL  = 6'b011000;
  localparam logic [5:0] F_AND  = 6'b100100;
  localparam logic [5:0] F_BRFL = 6'b111111;

  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic [REG_W-1:0]  rd;
    logic              wb_en;
    logic              br;
  } exp_t;

  logic                 clk;
  logic                 rst_n;
  logic                 flush;
  logic                 in_valid;
  logic                 in_ready;
  logic [DATA_W-1:0]    in_result;
  logic [FLAGS_W-1:0]   in_flags;
  logic [5:0]           in_func;
  logic [REG_W-1:0]     in_rd;
  logic                 in_wb_en;
  logic                 out_valid;
  logic                 out_ready;
  logic [DATA_W-1:0]    out_result;
  logic [REG_W-1:0]     out_rd;
  logic                 out_wb_en;
  logic                 out_branch_taken;
  logic [FLAGS_W-1:0]   flags_q;
  logic [OVF_CNT_W-1:0] ovf_count;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  alu_result_stage #(
    .DATA_W   (DATA_W),
    .REG_W    (REG_W),
    .FLAGS_W  (FLAGS_W),
    .OVF_CNT_W(OVF_CNT_W)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .flush           (flush),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_result       (in_result),
    .in_flags        (in_flags),
    .in_func         (in_func),
    .in_rd           (in_rd),
    .in_wb_en        (in_wb_en),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_result      (out_result),
    .out_rd          (out_rd),
    .out_wb_en       (out_wb_en),
    .out_branch_taken(out_branch_taken),
    .flags_q         (flags_q),
    .ovf_count       (ovf_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present an op; when it will be kept (no flush/reset), queue its expected output
  task automatic issue(input logic [5:0] func, input logic [DATA_W-1:0] res,
                       input logic [FLAGS_W-1:0] fl, input logic [REG_W-1:0] rd,
                       input logic wb, input logic exp_wb, input logic exp_br,
                       input logic keep);
    exp_t e;
    in_valid  = 1'b1;
    in_func   = func;
    in_result = res;
    in_flags  = fl;
    in_rd     = rd;
    in_wb_en  = wb;
    if (keep) begin
      e.result = res;
      e.rd     = rd;
      e.wb_en  = exp_wb;
      e.br     = exp_br;
      exp_q.push_back(e);
    end
  endtask

  // Monitor: a deliver happens at the next posedge whenever valid & ready now
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: got result 0x%0h, expected no output", out_result);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sb_result", 64'(out_result), 64'(e.result));
        check("sb_rd", 64'(out_rd), 64'(e.rd));
        check("sb_wb_en", 64'(out_wb_en), 64'(e.wb_en));
        check("sb_branch", 64'(out_branch_taken), 64'(e.br));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_result = '0;
    in_flags  = '0;
    in_func   = '0;
    in_rd     = '0;
    in_wb_en  = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();

    // Reset state
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_result", 64'(out_result), 64'd0);
    check("rst_out_rd", 64'(out_rd), 64'd0);
    check("rst_out_wb_en", 64'(out_wb_en), 64'd0);
    check("rst_branch", 64'(out_branch_taken), 64'd0);
    check("rst_flags", 64'(flags_q), 64'd0);
    check("rst_ovf", 64'(ovf_count), 64'd0);
    rst_n = 1'b1;
    tick();

    // Streaming ADDs 5,6,7 at full throughput
    out_ready = 1'b1;
    issue(F_ADD, 32'd5, 3'b000, 5'd1, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    check("s1_valid", 64'(out_valid), 64'd1);
    check("s1_result", 64'(out_result), 64'd5);
    check("s1_in_ready", 64'(in_ready), 64'd1);
    issue(F_ADD, 32'd6, 3'b000, 5'd2, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    check("s2_result", 64'(out_result), 64'd6);
    check("s2_in_ready", 64'(in_ready), 64'd1);
    issue(F_ADD, 32'd7, 3'b000, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    check("s3_result", 64'(out_result), 64'd7);
    check("s3_in_ready", 64'(in_ready), 64'd1);
    in_valid = 1'b0;
    tick();
    check("s_drained", 64'(out_valid), 64'd0);

    // Fill both entries with writeback stalled, then drain in order
    out_ready = 1'b0;
    issue(F_ADD, 32'd10, 3'b000, 5'd2, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    check("f1_in_ready", 64'(in_ready), 64'd1);
    issue(F_ADD, 32'd11, 3'b000, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    in_valid = 1'b0;
    check("f2_in_ready", 64'(in_ready), 64'd0);
    check("f2_head", 64'(out_result), 64'd10);
    tick();
    check("f2_hold_ready", 64'(in_ready), 64'd0);
    check("f2_hold_head", 64'(out_result), 64'd10);
    out_ready = 1'b1;
    tick();
    check("f3_head", 64'(out_result), 64'd11);
    check("f3_in_ready", 64'(in_ready), 64'd1);
    tick();
    check("f4_empty", 64'(out_valid), 64'd0);

    // Flags: arithmetic updates, logic op leaves them alone
    issue(F_SUB, 32'd3, 3'b010, 5'd4, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    check("flags_sub", 64'(flags_q), 64'b010);
    issue(F_AND, 32'd8, 3'b100, 5'd4, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    check("flags_and", 64'(flags_q), 64'b010);

    // BRFL resolution
    issue(F_BRFL, 32'd1, 3'b111, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1);
    tick();
    check("brfl1_taken", 64'(out_branch_taken), 64'd1);
    check("brfl1_wb_en", 64'(out_wb_en), 64'd0);
    check("brfl1_flags", 64'(flags_q), 64'b010);
    issue(F_BRFL, 32'd0, 3'b111, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    check("brfl0_taken", 64'(out_branch_taken), 64'd0);
    in_valid = 1'b0;
    tick();
    check("pre_flush_ovf", 64'(ovf_count), 64'd0);

    // Flush with two entries held and an overflowing ADD on the input
    out_ready = 1'b0;
    issue(F_ADD, 32'd20, 3'b010, 5'd6, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    issue(F_ADD, 32'd21, 3'b010, 5'd6, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    issue(F_ADD, 32'd22, 3'b001, 5'd6, 1'b1, 1'b1, 1'b0, 1'b0);
    flush = 1'b1;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    check("fl2_valid", 64'(out_valid), 64'd0);
    check("fl2_in_ready", 64'(in_ready), 64'd1);
    check("fl2_flags", 64'(flags_q), 64'b010);
    check("fl2_ovf", 64'(ovf_count), 64'd0);

    // Flush in ONE with an accept and a deliver in the same cycle
    issue(F_ADD, 32'd30, 3'b010, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    out_ready = 1'b1;
    issue(F_ADD, 32'd31, 3'b001, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0);
    flush = 1'b1;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("fl1_valid", 64'(out_valid), 64'd0);
    check("fl1_in_ready", 64'(in_ready), 64'd1);
    check("fl1_flags", 64'(flags_q), 64'b010);
    check("fl1_ovf", 64'(ovf_count), 64'd0);
    check("fl1_queue", 64'(exp_q.size()), 64'd0);

    // Overflow counter saturates at 3 with a 2-bit build
    for (int i = 0; i < 5; i++) begin
      issue(F_MUL, 32'(40 + i), 3'b001, 5'd8, 1'b1, 1'b1, 1'b0, 1'b1);
      tick();
      check("ovf_count", 64'(ovf_count), (i < 3) ? 64'(i + 1) : 64'd3);
    end
    check("ovf_flags", 64'(flags_q), 64'b001);

    // Reset mid-stream discards everything
    rst_n = 1'b0;
    issue(F_MUL, 32'd50, 3'b001, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    exp_q.delete();
    rst_n    = 1'b1;
    in_valid = 1'b0;
    check("mrst_valid", 64'(out_valid), 64'd0);
    check("mrst_in_ready", 64'(in_ready), 64'd1);
    check("mrst_result", 64'(out_result), 64'd0);
    check("mrst_rd", 64'(out_rd), 64'd0);
    check("mrst_wb_en", 64'(out_wb_en), 64'd0);
    check("mrst_flags", 64'(flags_q), 64'd0);
    check("mrst_ovf", 64'(ovf_count), 64'd0);

    // Recovery after reset
    issue(F_ADD, 32'd42, 3'b100, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    in_valid = 1'b0;
    check("rec_result", 64'(out_result), 64'd42);
    check("rec_flags", 64'(flags_q), 64'b100);
    tick();
    tick();
    check("rec_empty", 64'(out_valid), 64'd0);
    check("final_queue", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
- EX→WB pipeline stage directly downstream of the core ALU.
- Captures the ALU result, flags and destination info in a 2-entry skid buffer with valid/ready handshake toward writeback.
- Owns the architectural flags register that is fed back to the ALU `flags_in`.
- Resolves BRFL outcomes into a branch-taken signal and keeps a saturating overflow-event counter.

Parameters:
- DATA_W, 32, width of result datapath (signed two's complement).
- REG_W, 5, width of destination register index.
- FLAGS_W, 3, flags width: [2] above, [1] equals, [0] overflow.
- OVF_CNT_W, 16, width of saturating overflow-event counter.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on rising clk edge.
- flush  input  1  drop all buffered entries (pipeline kill).
- in_valid  input  1  upstream holds a valid ALU result.
- in_ready  output  1  stage can accept this cycle (registered).
- in_result  input  DATA_W  ALU result.
- in_flags  input  FLAGS_W  ALU flags_out.
- in_func  input  6  ALU function code of the op.
- in_rd  input  REG_W  destination register.
- in_wb_en  input  1  op writes the register file.
- out_valid  output  1  head entry valid.
- out_ready  input  1  writeback accepts head.
- out_result  output  DATA_W  head result.
- out_rd  output  REG_W  head destination.
- out_wb_en  output  1  head write enable (forced 0 for BRFL).
- out_branch_taken  output  1  head is BRFL and in_result[0] was 1.
- flags_q  output  FLAGS_W  architectural flags, to ALU flags_in.
- ovf_count  output  OVF_CNT_W  saturating count of accepted ops with overflow flag set.

Behaviour:
- Reset (rst_n=0 at edge): state EMPTY, out_valid=0, in_ready=1, out_result=0, out_rd=0, out_wb_en=0, out_branch_taken=0, flags_q=0, ovf_count=0. Reset overrides flush and any handshake mid-transfer; in-flight entries discarded.
- accept = in_valid & in_ready; deliver = out_valid & out_ready.
- State machine (main register M, skid register S):
  - EMPTY: accept → load M, go ONE.
  - ONE: accept & deliver → M ← input, stay ONE; accept & !deliver → S ← input, go TWO; !accept & deliver → go EMPTY; else hold.
  - TWO: deliver → M ← S, go ONE; else hold. No accept possible in TWO.
- in_ready is registered: 1 in EMPTY/ONE, 0 in TWO. It deasserts the cycle after the transition into TWO and reasserts the cycle after leaving TWO.
- Outputs always reflect M. In EMPTY, data outputs hold their last value; only out_valid is meaningful.
- Latency: accepted entry visible on outputs the next cycle; throughput 1/cycle when out_ready=1. Order strictly FIFO; no entry dropped or duplicated except by flush/reset.
- Entry capture:
  - BRFL (in_func=6'b111111): stored wb_en=0, branch_taken=in_result[0].
  - All other funcs: stored wb_en=in_wb_en, branch_taken=0.
- Flags register, updated only on accept:
  - Arithmetic funcs (100000, 100010, 011000, 011010): flags_q ← in_flags.
  - Logic ops (100100, 100101, 100111), BRFL and unknown codes: flags_q unchanged.
  - The update is visible to the ALU the cycle after accept.
- ovf_count: +1 on accept of an arithmetic func with in_flags[0]=1; saturates at all-ones, no wrap.
- flush=1 at edge: state EMPTY, out_valid=0, in_ready=1 next cycle.
  - A same-cycle accept is discarded, and its flags/ovf updates are suppressed.
  - A same-cycle deliver is still treated as consumed by writeback.
  - flags_q and ovf_count are otherwise retained.
- Simultaneous accept and deliver in ONE with flush=0 never stalls the input.

Test Plan:
- Reset then stream ADD results 5,6,7 with out_ready=1 → outputs 5,6,7 on consecutive cycles, 1-cycle latency, in_ready stays 1.
- out_ready=0, push results 10 then 11 → state TWO, in_ready=0 the cycle after the 2nd accept; raise out_ready → 10 then 11 delivered in order, in_ready back to 1.
- SUB with in_flags=3'b010, then AND with in_flags=3'b100 → flags_q=3'b010 after SUB and unchanged after AND.
- BRFL with in_result=1, in_wb_en=1 → out_branch_taken=1, out_wb_en=0, flags_q unchanged; with in_result=0 → out_branch_taken=0.
- Buffer holding 2 entries, flush=1 together with in_valid=1 carrying ADD with in_flags=3'b001 → next cycle out_valid=0, in_ready=1, flags_q and ovf_count unchanged.
- Preload ovf_count near saturation (OVF_CNT_W=2 build), send 5 overflowing MULs → ovf_count reads 3 and stays 3; rst_n=0 mid-stream → all outputs zero on the following cycle.
